idct_matmul_sequencer: RTL
==========================

# idct_matmul_sequencer

Sequences one 8x8 matrix product T = S x C for the IDCT stage of the image decompressor. S is a block of signed 16-bit pre-IDCT coefficients held in a 64-word block RAM. C is the 8x8 fixed-point DCT coefficient table, scaled by 4096 and looked up combinationally by (i, j). The block drives the read addresses for both sources, runs a single multiply-accumulate per cycle, and writes the 64 scaled results into the T buffer. The top-level decoder FSM launches it once per block with a start/done handshake.

## Interface
- SHIFT, default 8: arithmetic right shift applied to each accumulated sum before it is written.
- Clock  in  1  system clock; all state updates on the rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- start  in  1  launch request; sampled only when the block is idle.
- busy  out  1  high while a block is being processed.
- done  out  1  single-cycle pulse on completion.
- s_addr  out  6  S RAM read address, {r, k} with row-major order.
- s_rdata  in  16  signed S word; valid one cycle after s_addr.
- coef_i  out  3  coefficient table row index.
- coef_j  out  3  coefficient table column index.
- coef_value  in  32  signed C[coef_i][coef_j], combinational, same cycle.
- t_we  out  1  T buffer write enable.
- t_addr  out  6  T write address, {r, c}.
- t_wdata  out  32  signed result, acc >>> SHIFT.

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE -> RUN when start = 1.
  - RUN -> DRAIN after issue index n = 511.
  - DRAIN -> IDLE after the final write.
- Issue counter n is 9 bits, 0..511, and increments by 1 per RUN cycle.
  - r = n[8:6], c = n[5:3], k = n[2:0]; k is the innermost loop.
  - In issue cycle n: s_addr = {r, k}, coef_i = k, coef_j = c.
- Stage 1, the issue cycle: coef_value is registered into coef_q, and (r, c, k) are registered into the pipeline tags.
- Stage 2, the next cycle: product = s_rdata x coef_q.
  - The multiply is signed 16 x 32; only the low 32 bits of the product are kept.
  - acc is 32-bit signed. acc <= product when tag k = 0, else acc <= acc + product.
  - Coefficient magnitudes are at most 2008, so 8 products of a 16-bit input cannot overflow 32 bits. No saturation is applied.
- Stage 3: when tag k = 7 was accumulated in the previous cycle, the block asserts t_we = 1 with t_addr = {r, c} and t_wdata = acc >>> SHIFT.
  - The shift is arithmetic, so it floors toward minus infinity.
- Exactly 64 writes occur per run, with t_addr ascending 0..63.
- start while busy = 1 is ignored. There is no queuing.
- The S RAM contents must not change between start and done. The block has no check for this.
- Reset mid-operation: all state and outputs return to reset values immediately. The pending run is discarded and no further writes occur.

## Timing
- Reset values: busy = 0, done = 0, t_we = 0, s_addr = 0, coef_i = 0, coef_j = 0, t_addr = 0, t_wdata = 0, state = IDLE, n = 0, acc = 0.
- Cycle numbering: start is sampled high at edge E. T0 is the cycle after E.
  - busy = 1 from T0.
  - Issue n occurs in cycle T0 + n.
- The write for output (r, c) occurs in cycle T0 + 64r + 8c + 9.
  - First write: T0 + 9, t_addr = 0.
  - Last write: T0 + 513, t_addr = 63.
- busy = 1 for cycles T0 through T0 + 513 inclusive.
- In cycle T0 + 514: done = 1 for exactly one cycle, busy = 0, state = IDLE.
- start = 1 in the done cycle is accepted. The next run's T0 is then the done cycle + 1.
- Launch to launch period is 515 cycles.
- t_we is never high in consecutive-row gaps. There are exactly 8 cycles between successive writes.

## Test plan
- Reset: assert Resetn = 0 mid-cycle with start = 1 -> all outputs are 0 asynchronously and stay 0 while Resetn = 0.
- Impulse: S[0][0] = 4096, all others 0, SHIFT = 8 -> T[0][c] = 23168 for all c, and all other 56 outputs are 0.
- Negative and floor: S[1][1] = -1, others 0 -> T[1][0] = -8, T[1][3] = -2, T[1][4] = 1, T[1][7] = 7, all other rows 0.
- Timing: start pulse at E ->
  - first t_we at T0 + 9 with t_addr = 0;
  - last t_we at T0 + 513 with t_addr = 63;
  - 64 writes total, 8-cycle spacing;
  - done pulse exactly at T0 + 514;
  - every result matches a reference matrix product on a random S in the range [-2048, 2047].
- Handshake: start held high for 600 cycles -> back-to-back runs, done pulses 515 cycles apart. start pulses while busy -> no extra run.
- Mid-run reset: Resetn = 0 at T0 + 200 -> no writes after the reset edge. A fresh start after release -> full correct 64-write run.

Source files
------------

// File: rtl/idct_matmul_sequencer_if.sv
// Port bundle between idct_matmul_sequencer and its surroundings: decoder
// handshake, S RAM read port, coefficient table lookup and T buffer write port.
interface idct_matmul_sequencer_if;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned S_W    = 16;
    localparam int unsigned D_W    = 32;

    logic                     start;
    logic                     busy;
    logic                     done;
    logic [ADDR_W-1:0]        s_addr;
    logic signed [S_W-1:0]    s_rdata;
    logic [IDX_W-1:0]         coef_i;
    logic [IDX_W-1:0]         coef_j;
    logic signed [D_W-1:0]    coef_value;
    logic                     t_we;
    logic [ADDR_W-1:0]        t_addr;
    logic signed [D_W-1:0]    t_wdata;

    // Sequencer side
    modport slave (
        input  start, s_rdata, coef_value,
        output busy, done, s_addr, coef_i, coef_j, t_we, t_addr, t_wdata
    );

    // Decoder / memory side
    modport master (
        output start, s_rdata, coef_value,
        input  busy, done, s_addr, coef_i, coef_j, t_we, t_addr, t_wdata
    );
endinterface

// File: rtl/idct_matmul_sequencer.sv
// Sequences one 8x8 product T = S x C: one MAC per cycle over a 512-step
// issue counter, three-stage pipeline (issue, accumulate, write).
module idct_matmul_sequencer #(
    parameter int unsigned SHIFT = 8
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    idct_matmul_sequencer_if.slave bus
);
    localparam int unsigned N_W    = 9;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned ACC_W  = 32;
    localparam logic [N_W-1:0]    N_LAST = N_W'(511);
    localparam logic [ADDR_W-1:0] T_LAST = ADDR_W'(63);
    localparam logic [IDX_W-1:0]  K_LAST = IDX_W'(7);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] r;
        logic [IDX_W-1:0] c;
        logic [IDX_W-1:0] k;
    } tag_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [N_W-1:0]           r_n;
    tag_t                     r_tag;
    logic signed [ACC_W-1:0]  r_coef_q;
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_t_we;
    logic [ADDR_W-1:0]        r_t_addr;
    logic signed [ACC_W-1:0]  r_t_wdata;

    logic                     w_issue;
    logic                     w_done_nxt;
    logic                     w_busy_nxt;
    logic                     w_last_k;
    logic signed [ACC_W-1:0]  w_product;
    logic signed [ACC_W-1:0]  w_acc_nxt;

    // State register
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; the run ends once the write for (7,7) has gone out
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_done_nxt  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_issue = 1'b1;
                if (r_n == N_LAST) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (r_t_we && (r_t_addr == T_LAST)) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    // Stage 2 arithmetic: low 32 bits of the signed 16x32 product
    assign w_product = $signed(ACC_W'(bus.s_rdata)) * r_coef_q;
    assign w_acc_nxt = (r_tag.k == '0) ? w_product : (r_acc + w_product);
    assign w_last_k  = r_tag.valid && (r_tag.k == K_LAST);

    // Issue counter, pipeline registers and registered write port
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_n       <= '0;
            r_tag     <= '0;
            r_coef_q  <= '0;
            r_acc     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_t_we    <= 1'b0;
            r_t_addr  <= '0;
            r_t_wdata <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;

            if (w_issue) begin
                r_n      <= r_n + N_W'(1);
                r_coef_q <= bus.coef_value;
            end else begin
                r_n <= '0;
            end

            r_tag.valid <= w_issue;
            r_tag.r     <= r_n[8:6];
            r_tag.c     <= r_n[5:3];
            r_tag.k     <= r_n[2:0];

            if (r_tag.valid) begin
                r_acc <= w_acc_nxt;
            end

            r_t_we <= w_last_k;
            if (w_last_k) begin
                r_t_addr  <= {r_tag.r, r_tag.c};
                r_t_wdata <= w_acc_nxt >>> SHIFT;
            end
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.s_addr  = {r_n[8:6], r_n[2:0]};
    assign bus.coef_i  = r_n[2:0];
    assign bus.coef_j  = r_n[5:3];
    assign bus.t_we    = r_t_we;
    assign bus.t_addr  = r_t_addr;
    assign bus.t_wdata = r_t_wdata;

endmodule
